// File: rtl/int_root.sv
// Sequential integer n-th root: out = floor(inx^(1/inn)), built MSB-first by binary search
// with one saturating 16x16 multiply per cycle. Optional `exact` output under ROOT_EXACT_EN.
module int_root (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [15:0] inx,
  input  logic [7:0]  inn,
  output logic [15:0] out,
  output logic        ready,
  output logic        err
`ifdef ROOT_EXACT_EN
  ,
  output logic        exact
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_TRY,
    S_MUL,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [15:0] r_y;
  logic [7:0]  r_n;
  logic [15:0] r_r;
  logic [15:0] r_c;
  logic [15:0] r_p;
  logic [7:0]  r_cnt;
  logic [3:0]  r_i;
  logic [15:0] r_out;
  logic        r_ready;
  logic        r_err;
`ifdef ROOT_EXACT_EN
  logic        r_flag;
  logic        r_exact;
`endif

  logic [15:0] w_cand;
  logic [31:0] w_prod;
  logic        w_last;

  // A partial power that leaves 16 bits or exceeds the radicand can only grow, so reject.
  function automatic logic over_limit(input logic [31:0] prod, input logic [15:0] lim);
    return (prod[31:16] != 16'd0) || (prod[15:0] > lim);
  endfunction

  assign w_cand = r_r | (16'd1 << r_i);
  assign w_prod = {16'd0, r_p} * {16'd0, r_c};
  assign w_last = (r_i == 4'd0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_y     <= 16'd0;
      r_n     <= 8'd0;
      r_r     <= 16'd0;
      r_c     <= 16'd0;
      r_p     <= 16'd0;
      r_cnt   <= 8'd0;
      r_i     <= 4'd0;
      r_out   <= 16'd0;
      r_ready <= 1'b1;
      r_err   <= 1'b0;
`ifdef ROOT_EXACT_EN
      r_flag  <= 1'b0;
      r_exact <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_y     <= inx;
            r_n     <= inn;
            r_r     <= 16'd0;
            r_i     <= 4'd15;
            r_ready <= 1'b0;
            r_state <= S_CHECK;
`ifdef ROOT_EXACT_EN
            r_flag  <= 1'b0;
`endif
          end
        end

        S_CHECK: begin
          if (r_n == 8'd0) begin
            r_out   <= 16'hFFFF;
            r_err   <= 1'b1;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
`ifdef ROOT_EXACT_EN
            r_exact <= 1'b0;
`endif
          end else if (r_n == 8'd1 || r_y == 16'd0 || r_y == 16'd1) begin
            // For n=1 the root is y; for y in {0,1} it is also y.
            r_out   <= r_y;
            r_err   <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
`ifdef ROOT_EXACT_EN
            r_exact <= 1'b1;
`endif
          end else begin
            r_state <= S_TRY;
          end
        end

        S_TRY: begin
          r_c <= w_cand;
          if (w_cand == 16'd1) begin
            // 1^n = 1 <= y (y >= 2 here), and cannot equal y.
            r_r     <= w_cand;
`ifdef ROOT_EXACT_EN
            r_flag  <= 1'b0;
`endif
            if (w_last) r_state <= S_DONE;
            else begin
              r_i     <= r_i - 4'd1;
              r_state <= S_TRY;
            end
          end else begin
            r_p     <= 16'd1;
            r_cnt   <= r_n;
            r_state <= S_MUL;
          end
        end

        S_MUL: begin
          if (over_limit(w_prod, r_y)) begin
            if (w_last) r_state <= S_DONE;
            else begin
              r_i     <= r_i - 4'd1;
              r_state <= S_TRY;
            end
          end else if (r_cnt == 8'd1) begin
            r_r     <= r_c;
`ifdef ROOT_EXACT_EN
            r_flag  <= (w_prod[15:0] == r_y);
`endif
            if (w_last) r_state <= S_DONE;
            else begin
              r_i     <= r_i - 4'd1;
              r_state <= S_TRY;
            end
          end else begin
            r_p   <= w_prod[15:0];
            r_cnt <= r_cnt - 8'd1;
          end
        end

        S_DONE: begin
          r_out   <= r_r;
          r_err   <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
`ifdef ROOT_EXACT_EN
          r_exact <= r_flag;
`endif
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out   = r_out;
  assign ready = r_ready;
  assign err   = r_err;
`ifdef ROOT_EXACT_EN
  assign exact = r_exact;
`endif

endmodule

// File: tb/tb_int_root.sv
// Self-checking bench for int_root: directed requests checked against a behavioural root model,
// plus a per-cycle monitor that the visible result holds while the unit is busy.
module tb_int_root;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] inx = 16'd0;
  logic [7:0]  inn = 8'd0;
  logic [15:0] out;
  logic        ready;
  logic        err;
`ifdef ROOT_EXACT_EN
  logic        exact;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] hold_out = 16'd0;
  logic        hold_err = 1'b0;
  int lat;

  int_root dut (
    .clk   (clk),
    .nrst  (nrst),
    .start (start),
    .inx   (inx),
    .inn   (inn),
    .out   (out),
    .ready (ready),
    .err   (err)
`ifdef ROOT_EXACT_EN
    ,
    .exact (exact)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // c^n, capped at lim+1 once it exceeds lim.
  function automatic longint pw(input longint c, input int n, input longint lim);
    longint p = 1;
    for (int k = 0; k < n; k++) begin
      p = p * c;
      if (p > lim) return lim + 1;
    end
    return p;
  endfunction

  function automatic int m_root(input int y, input int n);
    int r = 0;
    if (n == 0) return 65535;
    for (longint c = 1; c <= 65535; c++) begin
      if (pw(c, n, y) <= y) r = int'(c);
      else break;
    end
    return r;
  endfunction

  function automatic int m_exact(input int y, input int n);
    if (n == 0) return 0;
    return (pw(m_root(y, n), n, y) == y) ? 1 : 0;
  endfunction

  // Latency from the start edge to ready=1: 1 for special cases, else 2 + sum(1+m_i).
  function automatic int m_lat(input int y, input int n);
    int r = 0;
    int s = 0;
    if (n == 0 || n == 1 || y == 0 || y == 1) return 1;
    for (int i = 15; i >= 0; i--) begin
      int c = r | (1 << i);
      int m = n;
      bit acc = 1'b1;
      longint p = 1;
      if (c == 1) begin
        r = c;
        s += 1;
        continue;
      end
      for (int j = 1; j <= n; j++) begin
        p = p * c;
        if (p > y) begin
          m = j;
          acc = 1'b0;
          break;
        end
      end
      if (acc) r = c;
      s += 1 + m;
    end
    return 2 + s;
  endfunction

  task automatic run(input int y, input int n, input bit disturb, output int l);
    int e;
    @(negedge clk);
    inx = y[15:0];
    inn = n[7:0];
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    l = 0;
    chk("busy_after_start", ready, 0);
    while (l < 400) begin
      @(posedge clk);
      l++;
      #1;
      if (ready) break;
      if (disturb && l == 3) begin
        start = 1'b1;
        inx = 16'd4321;
        inn = 8'd2;
      end
      if (disturb && l == 4) start = 1'b0;
    end
    chk("ready_within_bound", ready, 1);
    e = m_root(y, n);
    chk("out", out, e);
    chk("err", err, (n == 0) ? 1 : 0);
`ifdef ROOT_EXACT_EN
    chk("exact", exact, m_exact(y, n));
`endif
    chk("latency", l, m_lat(y, n));
    hold_out = e[15:0];
    hold_err = (n == 0);
  endtask

  // While busy, out/err must still show the previous completed result.
  always @(negedge clk) begin
    if (nrst && !ready) begin
      chk("hold_out", out, hold_out);
      chk("hold_err", err, hold_err);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_ready", ready, 1);
    chk("reset_out", out, 0);
    chk("reset_err", err, 0);
`ifdef ROOT_EXACT_EN
    chk("reset_exact", exact, 0);
`endif
    nrst = 1'b1;

    chk("pin_root_1000_3", m_root(1000, 3), 10);
    chk("pin_root_65535_2", m_root(65535, 2), 255);
    chk("pin_root_32768_15", m_root(32768, 15), 2);
    chk("pin_root_81_4", m_root(81, 4), 3);
    chk("pin_exact_1000_3", m_exact(1000, 3), 1);
    chk("pin_exact_65535_2", m_exact(65535, 2), 0);
    chk("pin_lat_65535_255", m_lat(65535, 255), 78);
    chk("pin_lat_special", m_lat(500, 0), 1);

    run(1000, 3, 1'b0, lat);
    chk("lit_1000_3", out, 10);
    run(65535, 2, 1'b0, lat);
    chk("lit_65535_2", out, 255);
    run(32768, 15, 1'b0, lat);
    chk("lit_32768_15", out, 2);
    run(500, 0, 1'b0, lat);
    chk("lit_n0_out", out, 16'hFFFF);
    chk("lit_n0_lat", lat, 1);
    run(7, 1, 1'b0, lat);
    chk("lit_n1", out, 7);
    run(0, 5, 1'b0, lat);
    chk("lit_y0", out, 0);
    run(1, 9, 1'b0, lat);
    run(2, 2, 1'b0, lat);
    run(65535, 255, 1'b0, lat);
    chk("lit_65535_255", out, 1);
    chk("lat_le_290", (lat <= 290) ? 1 : 0, 1);
    run(65535, 16, 1'b0, lat);
    run(1000, 3, 1'b1, lat);
    chk("lit_disturbed", out, 10);

    // Abort a long request with an asynchronous reset.
    @(negedge clk);
    inx = 16'd65535;
    inn = 8'd255;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    nrst = 1'b0;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_out", out, 0);
    chk("abort_err", err, 0);
`ifdef ROOT_EXACT_EN
    chk("abort_exact", exact, 0);
`endif
    hold_out = 16'd0;
    hold_err = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    run(81, 4, 1'b0, lat);
    chk("lit_81_4", out, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int_root.md
# int_root

Sequential integer n-th root unit: computes floor(y^(1/n)) for a 16-bit radicand y and an 8-bit exponent n. It is the inverse of the team's start/ready fast-power block and shares its handshake. The result is built MSB-first by bit-wise binary search, with one saturating 16x16 multiply per cycle to test each candidate. It sits beside the power unit in the Lista11 arithmetic set and is driven by the same controller.

## Interface
- No parameters. Widths are fixed: radicand 16, exponent 8, result 16.
- clk  input  1  clock; all state changes on the rising edge.
- nrst  input  1  reset, asynchronous, active-low.
- start  input  1  request. Sampled only while ready=1.
- inx  input  16  radicand y, unsigned.
- inn  input  8  exponent n, unsigned.
- out  output  16  result r = max r such that r^n <= y. Holds its value until the next completion.
- ready  output  1  1 = idle or done; 0 = busy.
- err  output  1  1 when the last request had n=0. Updated together with out.

## Operation
- States: IDLE, CHECK, TRY, MUL, DONE.
- IDLE (ready=1). When start=1:
  - Latch y<=inx and n<=inn.
  - Clear r<=0 and set bit index i<=15.
  - Set ready<=0 and go to CHECK.
- CHECK resolves special cases directly:
  - n=0 → out=16'hFFFF, err=1.
  - n=1 → out=y.
  - y=0 → out=0.
  - y=1 → out=1.
  - Otherwise go to TRY.
- TRY:
  - Candidate c = r | (1<<i).
  - If c=1, accept without multiplying (y>=2 here).
  - Otherwise load p<=1, cnt<=n and go to MUL.
- MUL, one multiply per cycle: prod = p*c, 32-bit.
  - Overflow: prod[31:16]!=0 or prod[15:0]>y → reject c.
  - Else if cnt=1 → accept c (c^n<=y).
  - Else p<=prod[15:0], cnt<=cnt-1, and stay in MUL.
- Decision:
  - Accept sets r<=c; reject leaves r unchanged.
  - If i=0, go to DONE. Otherwise i<=i-1 and go to TRY.
- DONE: out<=r, err<=0, ready<=1, then go to IDLE.
- start while ready=0 is ignored. Input changes while busy have no effect.
- No intermediate value is ever visible on out.

## Timing
- Reset values: ready=1, out=16'h0000, err=0, state IDLE.
- Asynchronous reset mid-operation aborts immediately; the request is lost.
- Edge numbering: edge 0 samples start. ready falls after edge 0.
- Special cases: out, err and ready=1 are all updated at edge 1 (the CHECK edge).
- General case:
  - Each bit costs 1 TRY cycle plus m_i MUL cycles.
  - m_i = min(n, smallest j with c^j > y), and m_i = 0 when c=1.
  - DONE adds 1 cycle.
  - Total latency = 2 + Σ(1+m_i) edges until ready=1.
- Since c>=2 exceeds 16 bits within 17 multiplies, m_i <= 17 and worst-case latency <= 290 cycles.
- ready=1 and out are valid in the same cycle.
- A new start is accepted in the first cycle ready=1 is seen.

## Configuration
- ROOT_EXACT_EN defined:
  - Adds output `exact` (1 bit, reset 0), updated with out.
  - `exact`=1 iff out^n == y.
  - Tracked as a flag set on each accept: the flag is (final prod[15:0]==y).
  - Special cases: n=1, y=0 and y=1 give exact=1; n=0 gives exact=0.
- ROOT_EXACT_EN undefined: the port and its flag logic are absent. All other behaviour and timing are identical.

## Test plan
- After reset: ready=1, out=0, err=0. Then y=1000, n=3 → out=10, err=0, exact=1.
- y=65535, n=2 → out=255, exact=0. Then y=32768, n=15 → out=2, exact=1.
- Special cases:
  - n=0, y=500 → out=16'hFFFF, err=1, ready high at edge 1.
  - n=1, y=7 → out=7.
  - y=0, n=5 → out=0.
- y=65535, n=255 → out=1, exact=0. Measured latency must equal the formula and be <= 290.
- Pulse start again while busy with different inputs → ignored; the original result is returned.
- Assert nrst mid-computation → ready=1, out=0 immediately. A following request y=81, n=4 → out=3.
